// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the fetch PC generator.
// State enum, next-PC source enum, default reset vector.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_3000;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HALTED
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_RAS,
    SRC_SEQ,
    SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake between the PC generator and fetch.
// master drives fetch_valid/fetch_pc; slave returns fetch_ready.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;

  modport master (
    output fetch_valid,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    output fetch_ready
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with occupancy count.
// Ports: clk, rstn, push_i/push_addr_i, pop_i, top_o, empty_o.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] C1 = (PW+1)'(1);
  localparam logic [PW-1:0] P1 = PW'(1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr_en, pop_ok;

  // ptr_q is the next free slot; the top sits just below it
  assign top_idx = ptr_q - P1;
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    priority case (1'b1)
      // pop sees the old top, push reuses its slot
      push_i && pop_ok: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      push_i: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + P1;
        cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + C1;
      end
      pop_ok: begin
        ptr_d = top_idx;
        cnt_d = cnt_q - C1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_addr_i;
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap/redirect/RAS/sequential update
// and BOOT/RUN/HALTED control. Fetch handshake via pc_gen_if.master;
// misalign pulses after a misaligned load. Return stack under PC_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int unsigned     INST_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  pc_gen_if.master        fetch,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  output logic            misalign,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] LOW  = XLEN'(INST_BYTES - 1);

  pc_state_e       state_q, state_d;
  pc_src_e         src;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt, ras_top;
  logic            mis_q, mis_d;
  logic            run, load;

  assign run               = (state_q == PC_RUN);
  assign fetch.fetch_valid = run;
  assign fetch.fetch_pc    = pc_q;
  assign misalign          = mis_q;

`ifdef PC_RAS_EN
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (run && ras_push),
    .push_addr_i (ras_push_addr),
    .pop_i       (src == SRC_RAS),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  always_comb begin
    src = SRC_HOLD;
    priority case (1'b1)
      trap_valid:                     src = SRC_TRAP;
      run && redirect_valid:          src = SRC_REDIRECT;
      run && ras_pop && !ras_empty:   src = SRC_RAS;
      run && fetch.fetch_ready
          && !stall:                  src = SRC_SEQ;
      default:                        src = SRC_HOLD;
    endcase
  end

  always_comb begin
    tgt  = '0;
    load = 1'b0;
    unique case (src)
      SRC_TRAP:     begin tgt = trap_vector;     load = 1'b1; end
      SRC_REDIRECT: begin tgt = redirect_target; load = 1'b1; end
      SRC_RAS:      begin tgt = ras_top;         load = 1'b1; end
      default:      ;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (load) begin
      // misaligned targets still load, with low bits cleared
      pc_d  = tgt & ~LOW;
      mis_d = |(tgt & LOW);
    end else if (src == SRC_SEQ) begin
      pc_d = pc_q + STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PC_BOOT:   state_d = PC_RUN;
      PC_RUN:    if (halt_req) state_d = PC_HALTED;
      PC_HALTED: if (trap_valid) state_d = PC_RUN;
      default:   state_d = PC_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of pc_gen against hand-computed values.
// Covers boot, advance, redirect/trap priority, misalign, halt, wrap, RAS.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, redirect_valid, trap_valid, halt_req;
  logic [31:0] redirect_target, trap_vector, ras_push_addr;
  logic        misalign, ras_push, ras_pop, ras_empty;

  int n_chk = 0;
  int n_bad = 0;

  pc_gen_if #(.XLEN(32)) fif ();

  pc_gen dut (
    .clk             (clk),
    .rstn            (rstn),
    .fetch           (fif),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .misalign        (misalign),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ras_pop         (ras_pop),
    .ras_empty       (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    trap_valid = 1'b0;
    trap_vector = '0;
    halt_req = 1'b0;
    ras_push = 1'b0;
    ras_pop = 1'b0;
    ras_push_addr = '0;
    fif.fetch_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(fif.fetch_valid), 0);
    check("rst_pc", fif.fetch_pc, 32'h3000);
    check("rst_mis", 32'(misalign), 0);
    check("rst_empty", 32'(ras_empty), 1);

    rstn = 1'b1;
    #1;
    check("boot_valid", 32'(fif.fetch_valid), 0);
    step();
    check("run_valid", 32'(fif.fetch_valid), 1);
    check("seq0", fif.fetch_pc, 32'h3000);
    step();
    check("seq1", fif.fetch_pc, 32'h3004);
    step();
    check("seq2", fif.fetch_pc, 32'h3008);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h4000;
    step();
    check("redir_stall", fif.fetch_pc, 32'h4000);
    check("redir_mis", 32'(misalign), 0);
    redirect_valid = 1'b0;
    stall = 1'b0;
    fif.fetch_ready = 1'b0;
    step();
    check("nordy_hold0", fif.fetch_pc, 32'h4000);
    step();
    check("nordy_hold1", fif.fetch_pc, 32'h4000);
    fif.fetch_ready = 1'b1;
    stall = 1'b1;
    step();
    check("stall_hold", fif.fetch_pc, 32'h4000);
    stall = 1'b0;

    trap_valid = 1'b1;
    trap_vector = 32'h100;
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    step();
    check("trap_prio", fif.fetch_pc, 32'h100);
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("after_trap", fif.fetch_pc, 32'h104);

    redirect_valid = 1'b1;
    redirect_target = 32'h4002;
    step();
    check("mis_pc", fif.fetch_pc, 32'h4000);
    check("mis_set", 32'(misalign), 1);
    redirect_valid = 1'b0;
    step();
    check("mis_clr", 32'(misalign), 0);
    check("mis_next", fif.fetch_pc, 32'h4004);

    halt_req = 1'b1;
    step();
    check("halt_valid", 32'(fif.fetch_valid), 0);
    check("halt_pc", fif.fetch_pc, 32'h4008);
    halt_req = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h500;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_frz_pc", fif.fetch_pc, 32'h4008);
      check("halt_frz_v", 32'(fif.fetch_valid), 0);
    end
    redirect_valid = 1'b0;
    trap_valid = 1'b1;
    trap_vector = 32'h80;
    step();
    check("wake_valid", 32'(fif.fetch_valid), 1);
    check("wake_pc", fif.fetch_pc, 32'h80);

    trap_vector = 32'hFFFF_FFFC;
    step();
    check("wrap_top", fif.fetch_pc, 32'hFFFF_FFFC);
    trap_valid = 1'b0;
    step();
    check("wrap_zero", fif.fetch_pc, 32'h0);

`ifdef PC_RAS_EN
    fif.fetch_ready = 1'b0;
    ras_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ras_push_addr = 32'(i * 16);
      step();
    end
    ras_push = 1'b0;
    check("ras_nonempty", 32'(ras_empty), 0);
    check("ras_push_hold", fif.fetch_pc, 32'h0);
    ras_pop = 1'b1;
    step();
    check("pop0", fif.fetch_pc, 32'h50);
    step();
    check("pop1", fif.fetch_pc, 32'h40);
    step();
    check("pop2", fif.fetch_pc, 32'h30);
    step();
    check("pop3", fif.fetch_pc, 32'h20);
    check("ras_empty4", 32'(ras_empty), 1);
    step();
    check("pop_empty", fif.fetch_pc, 32'h20);
    ras_pop = 1'b0;
    ras_push = 1'b1;
    ras_push_addr = 32'h60;
    step();
    ras_push_addr = 32'h70;
    ras_pop = 1'b1;
    step();
    check("pushpop_pc", fif.fetch_pc, 32'h60);
    check("pushpop_cnt", 32'(ras_empty), 0);
    ras_push = 1'b0;
    step();
    check("pushpop_new", fif.fetch_pc, 32'h70);
    check("pushpop_emp", 32'(ras_empty), 1);
    ras_pop = 1'b0;
    fif.fetch_ready = 1'b1;
`else
    ras_push = 1'b1;
    ras_push_addr = 32'h10;
    step();
    check("noras_push", fif.fetch_pc, 32'h4);
    check("noras_empty", 32'(ras_empty), 1);
    ras_push = 1'b0;
    ras_pop = 1'b1;
    step();
    check("noras_pop", fif.fetch_pc, 32'h8);
    ras_pop = 1'b0;
`endif

    rstn = 1'b0;
    trap_valid = 1'b1;
    trap_vector = 32'h900;
    step();
    check("midrst_pc", fif.fetch_pc, 32'h3000);
    check("midrst_v", 32'(fif.fetch_valid), 0);
    trap_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
